// File: rtl/riscv_pkg.sv
// Shared EX-stage encodings: ALU control codes, MDU op codes and the
// iterative sequencer's state type.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_DIVU = 2'b01;
  localparam logic [1:0] MDU_REMU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Reserved op 2'b11 runs as MUL, so only the two divide codes count here.
  function automatic logic mdu_is_div(input logic [1:0] op);
    return (op == MDU_DIVU) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Bundle between the EX stage (requester plus shared ALU) and the MDU sequencer.
// Handshake: start is sampled only while busy=0; flush wins over start; done is a
// one-cycle pulse with result valid in that cycle, and result holds until the next
// accepted start.
interface alu_mdu_seq_if
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  state_t           state;

  modport slave (
    input  start, op, src_a, src_b, flush, alu_out,
    output busy, done, result, alu_a, alu_b, alu_ctrl, state
  );

  modport master (
    output start, op, src_a, src_b, flush, alu_out,
    input  busy, done, result, alu_a, alu_b, alu_ctrl, state
  );

endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring unsigned divide.
// x = acc/rem, y = mcand/divisor, z = mplier/quo.
module mdu_step
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic [WIDTH-1:0] z_next
);

  logic [WIDTH-1:0] rs;
  logic             carry;
  logic             take;

  always_comb begin
    rs       = {x[WIDTH-2:0], z[WIDTH-1]};
    carry    = x[WIDTH-1];
    // The bit shifted out of rem is the implicit MSB of the partial remainder.
    take     = carry || (rs >= y);
    alu_a    = x;
    alu_b    = y;
    alu_ctrl = ALU_ADD;
    x_next   = z[0] ? alu_out : x;
    y_next   = y << 1;
    z_next   = z >> 1;
    if (is_div) begin
      alu_a    = rs;
      alu_b    = y;
      alu_ctrl = ALU_SUB;
      x_next   = take ? alu_out : rs;
      y_next   = y;
      z_next   = {z[WIDTH-2:0], take};
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Iterative MUL/DIVU/REMU sequencer that borrows the EX-stage ALU for one
// add or subtract per cycle, WIDTH cycles per operation.
module alu_mdu_seq
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_mdu_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] result_q;

  logic             op_div;
  logic             div_zero;
  logic             accept;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic [3:0]       step_ctrl;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] z_next;

  assign op_div   = mdu_is_div(bus.op);
  assign div_zero = op_div && (bus.src_b == '0);
  assign accept   = (state == IDLE) && bus.start && !bus.flush;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (mdu_is_div(op_q)),
    .x        (x_q),
    .y        (y_q),
    .z        (z_q),
    .alu_out  (bus.alu_out),
    .alu_a    (step_a),
    .alu_b    (step_b),
    .alu_ctrl (step_ctrl),
    .x_next   (x_next),
    .y_next   (y_next),
    .z_next   (z_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = ALU_ADD;
    unique case (state)
      IDLE: begin
        if (accept) state_next = div_zero ? DONE : RUN;
      end
      RUN: begin
        bus.busy     = 1'b1;
        bus.alu_a    = step_a;
        bus.alu_b    = step_b;
        bus.alu_ctrl = step_ctrl;
        if (cnt == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= MDU_MUL;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= bus.op;
      x_q  <= '0;
      y_q  <= op_div ? bus.src_b : bus.src_a;
      z_q  <= op_div ? bus.src_a : bus.src_b;
      if (div_zero) result_q <= (bus.op == MDU_DIVU) ? '1 : bus.src_a;
    end else if ((state == RUN) && !bus.flush) begin
      cnt <= cnt + CNT_W'(1);
      x_q <= x_next;
      y_q <= y_next;
      z_q <= z_next;
      if (cnt == CNT_LAST) result_q <= (op_q == MDU_DIVU) ? z_next : x_next;
    end
  end

  assign bus.result = result_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed and random checks of alu_mdu_seq against plain-arithmetic expectations.
module tb_alu_mdu_seq;
  import riscv_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  alu_mdu_seq_if #(.WIDTH(W)) dut_if ();

  alu_mdu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EX-stage ALU
  always_comb begin
    case (dut_if.alu_ctrl)
      ALU_ADD: dut_if.alu_out = dut_if.alu_a + dut_if.alu_b;
      ALU_SUB: dut_if.alu_out = dut_if.alu_a - dut_if.alu_b;
      ALU_XOR: dut_if.alu_out = dut_if.alu_a ^ dut_if.alu_b;
      ALU_OR:  dut_if.alu_out = dut_if.alu_a | dut_if.alu_b;
      ALU_AND: dut_if.alu_out = dut_if.alu_a & dut_if.alu_b;
      default: dut_if.alu_out = '0;
    endcase
  end

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    case (o)
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] b);
    return ((o == 2'b01 || o == 2'b10) && b == 0) ? 1 : W + 1;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    logic is_div;
    logic busy_bad;
    logic ctrl_bad;
    is_div   = (o == 2'b01) || (o == 2'b10);
    busy_bad = 1'b0;
    ctrl_bad = 1'b0;
    @(negedge clk);
    dut_if.start = 1'b1;
    dut_if.op    = o;
    dut_if.src_a = a;
    dut_if.src_b = b;
    exp_q.push_back(ref_model(o, a, b));
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    cyc = 1;
    while (!dut_if.done && cyc < 100) begin
      if (dut_if.busy !== 1'b1) busy_bad = 1'b1;
      if (dut_if.alu_ctrl !== (is_div ? ALU_SUB : ALU_ADD)) ctrl_bad = 1'b1;
      // operands are latched, and start while busy must be ignored
      dut_if.src_a = $urandom;
      dut_if.src_b = $urandom;
      dut_if.op    = 2'($urandom_range(0, 3));
      dut_if.start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", {31'b0, dut_if.done}, 32'd1);
    check("busy_while_run", {31'b0, busy_bad}, 32'd0);
    check("alu_ctrl_run", {31'b0, ctrl_bad}, 32'd0);
    check("latency", 32'(cyc), 32'(ref_latency(o, b)));
    check("busy_at_done", {31'b0, dut_if.busy}, 32'd1);
    last_res = exp_q.pop_front();
    check("result", dut_if.result, last_res);
    dut_if.start = 1'b1;
    dut_if.op    = 2'b01;
    dut_if.src_b = '0;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    check("done_falls", {31'b0, dut_if.done}, 32'd0);
    check("idle_after_done", {31'b0, dut_if.busy}, 32'd0);
    check("result_held", dut_if.result, last_res);
    if (dut_if.busy) begin
      @(negedge clk); dut_if.flush = 1'b1;
      @(posedge clk); #1; dut_if.flush = 1'b0;
    end
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         saw_done;
    dut_if.start = 1'b0;
    dut_if.op    = 2'b00;
    dut_if.src_a = '0;
    dut_if.src_b = '0;
    dut_if.flush = 1'b0;
    reset        = 1'b1;
    last_res     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, dut_if.busy}, 32'd0);
    check("rst_done", {31'b0, dut_if.done}, 32'd0);
    check("rst_result", dut_if.result, 32'd0);
    check("rst_alu_a", dut_if.alu_a, 32'd0);
    check("rst_alu_b", dut_if.alu_b, 32'd0);
    check("rst_alu_ctrl", {28'b0, dut_if.alu_ctrl}, {28'b0, ALU_ADD});
    check("rst_state", {30'b0, dut_if.state}, {30'b0, IDLE});
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'd7, 32'd6);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 32'd100, 32'd7);
    run_op(2'b10, 32'd100, 32'd7);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op(2'b01, 32'd5, 32'd0);
    run_op(2'b10, 32'd5, 32'd0);
    run_op(2'b00, 32'd3, 32'd4);
    run_op(2'b01, 32'd12, 32'd4);
    run_op(2'b11, 32'd9, 32'd11);

    // flush in cycle 10 of a MUL
    @(negedge clk);
    dut_if.start = 1'b1; dut_if.op = 2'b00; dut_if.src_a = 32'd123; dut_if.src_b = 32'd456;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); dut_if.flush = 1'b1;
    @(posedge clk); #1; dut_if.flush = 1'b0;
    check("flush_busy", {31'b0, dut_if.busy}, 32'd0);
    check("flush_done", {31'b0, dut_if.done}, 32'd0);
    check("flush_result", dut_if.result, last_res);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dut_if.done) saw_done = 1'b1;
    end
    check("flush_no_done", {31'b0, saw_done}, 32'd0);

    // flush beats start in IDLE
    @(negedge clk);
    dut_if.start = 1'b1; dut_if.flush = 1'b1; dut_if.op = 2'b01; dut_if.src_a = 32'd5; dut_if.src_b = '0;
    @(posedge clk); #1;
    dut_if.start = 1'b0; dut_if.flush = 1'b0;
    check("flush_start_busy", {31'b0, dut_if.busy}, 32'd0);
    check("flush_start_done", {31'b0, dut_if.done}, 32'd0);
    check("flush_start_result", dut_if.result, last_res);

    // asynchronous reset in cycle 20 of a DIVU
    @(negedge clk);
    dut_if.start = 1'b1; dut_if.op = 2'b01; dut_if.src_a = 32'hDEAD_BEEF; dut_if.src_b = 32'd3;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    repeat (19) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("areset_busy", {31'b0, dut_if.busy}, 32'd0);
    check("areset_done", {31'b0, dut_if.done}, 32'd0);
    check("areset_result", dut_if.result, 32'd0);
    check("areset_alu_ctrl", {28'b0, dut_if.alu_ctrl}, {28'b0, ALU_ADD});
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    run_op(2'b01, 32'd9, 32'd3);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
